mmu_dcache_req_sched: RTL

- Schedules load/store accesses from two requesters onto the single E1 MMU/D$ access slot: the processor LSU and the hardware page-table walker.
- Arbitrates between them, holds the E1 request stable until the D$ grants it, and tracks each accepted access through E2 (MMU translate/trap) and E3 (D$ data).
- Returns per-requester done/trap pulses.
- Sits between the LSU/walker and the MMU/D$ E1 request interface.

---
 rtl/mmu_dcache_req_sched_if.sv | 31 +++
 rtl/mmu_dcache_req_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mmu_dcache_req_sched_if.sv
// E1 request bus between the scheduler and the MMU/D$ access slot.
// Latency: none (wires only).
// Backpressure: dcache_e1_grant_i_s from the D$ accepts the offered request.
// Ports: master = scheduler (drives req/addr/size/opc, samples grant);
//        slave  = MMU/D$ (samples request, drives grant).
interface mmu_dcache_req_sched_if #(
  parameter int ADDR_W = 41,
  parameter int OPC_W  = 4
);
  logic              e1_dcache_req_m;
  logic [ADDR_W-1:0] e1_dcache_virt_addr_m;
  logic [3:0]        e1_dcache_size_m;
  logic [OPC_W-1:0]  e1_dcache_opc_m;
  logic              dcache_e1_grant_i_s;

  modport master (
    output e1_dcache_req_m,
    output e1_dcache_virt_addr_m,
    output e1_dcache_size_m,
    output e1_dcache_opc_m,
    input  dcache_e1_grant_i_s
  );

  modport slave (
    input  e1_dcache_req_m,
    input  e1_dcache_virt_addr_m,
    input  e1_dcache_size_m,
    input  e1_dcache_opc_m,
    output dcache_e1_grant_i_s
  );
endinterface

// File: rtl/mmu_dcache_req_sched.sv
// Schedules LSU (proc) and page-table-walker accesses onto the single E1 MMU/D$ slot.
// Latency: ack in the E1 grant cycle, trap one cycle later, done two cycles later (no stalls).
// Backpressure: E1 is offered only when E2 can take it; a refused request is locked to its owner.
// Ports: clock/reset; p_* proc requester; w_* walker requester; e1 = E1 bus (interface, master);
//        e2_stall_m / e2_trap_any_i = MMU E2 status; dcache_e3_stall_i_s = D$ E3 stall.
// Optional: define MMU_DCACHE_SCHED_PERF_EN to add perf_issue_cnt_o / perf_hold_cnt_o.
module mmu_dcache_req_sched #(
  parameter int ADDR_W     = 41,
  parameter int OPC_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [3:0]        p_size_i,
  input  logic [OPC_W-1:0]  p_opc_i,
  output logic              p_ack_o,
  output logic              p_done_o,
  output logic              p_trap_o,
  input  logic              w_req_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [3:0]        w_size_i,
  input  logic [OPC_W-1:0]  w_opc_i,
  output logic              w_ack_o,
  output logic              w_done_o,
  output logic              w_trap_o,
  mmu_dcache_req_sched_if.master e1,
  input  logic              e2_stall_m,
  input  logic              e2_trap_any_i,
  input  logic              dcache_e3_stall_i_s
`ifdef MMU_DCACHE_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt_o,
  output logic [31:0]       perf_hold_cnt_o
`endif
);

  typedef enum logic {OWN_P = 1'b0, OWN_W = 1'b1} owner_e;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic   lock_vld_q, lock_vld_d;
  owner_e lock_own_q, lock_own_d;
  logic   e2_vld_q, e2_vld_d;
  owner_e e2_own_q, e2_own_d;
  logic   e3_vld_q, e3_vld_d;
  owner_e e3_own_q, e3_own_d;
  logic [3:0] starve_q, starve_d;

  logic   e3_adv, e3_free, e2_adv, e2_kill, e2_free;
  owner_e win;
  logic   win_req, e1_req, xfer;

  always_comb begin
    e3_adv  = e3_vld_q & ~dcache_e3_stall_i_s;
    e3_free = ~e3_vld_q | e3_adv;
    e2_adv  = e2_vld_q & ~e2_stall_m & e3_free;
    e2_kill = e2_adv & e2_trap_any_i;
    e2_free = ~e2_vld_q | e2_adv;

    // A locked request keeps its owner until granted; otherwise proc has priority
    // unless the walker has been passed over STARVE_MAX times in a row.
    if (lock_vld_q)                                          win = lock_own_q;
    else if (p_req_i && !(w_req_i && starve_q == STARVE_LIM)) win = OWN_P;
    else if (w_req_i)                                        win = OWN_W;
    else                                                     win = OWN_P;

    win_req = (win == OWN_W) ? w_req_i : p_req_i;
    // Gating with reset keeps every output low while reset is held, even if
    // the requesters are still driving their request lines.
    e1_req  = win_req & e2_free & reset;
    xfer    = e1_req & e1.dcache_e1_grant_i_s;
  end

  assign e1.e1_dcache_req_m       = e1_req;
  assign e1.e1_dcache_virt_addr_m = !e1_req ? '0 : (win == OWN_W) ? w_addr_i : p_addr_i;
  assign e1.e1_dcache_size_m      = !e1_req ? '0 : (win == OWN_W) ? w_size_i : p_size_i;
  assign e1.e1_dcache_opc_m       = !e1_req ? '0 : (win == OWN_W) ? w_opc_i  : p_opc_i;

  assign p_ack_o  = xfer & (win == OWN_P);
  assign w_ack_o  = xfer & (win == OWN_W);
  assign p_done_o = e3_adv & (e3_own_q == OWN_P);
  assign w_done_o = e3_adv & (e3_own_q == OWN_W);
  assign p_trap_o = e2_kill & (e2_own_q == OWN_P);
  assign w_trap_o = e2_kill & (e2_own_q == OWN_W);

  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    e2_vld_d   = e2_vld_q;
    e2_own_d   = e2_own_q;
    e3_vld_d   = e3_vld_q;
    e3_own_d   = e3_own_q;
    starve_d   = starve_q;

    // E3: a surviving E2 access replaces whatever retires this cycle.
    if (e2_adv && !e2_trap_any_i) begin
      e3_vld_d = 1'b1;
      e3_own_d = e2_own_q;
    end else if (e3_adv) begin
      e3_vld_d = 1'b0;
    end

    if (xfer) begin
      e2_vld_d = 1'b1;
      e2_own_d = win;
    end else if (e2_adv) begin
      e2_vld_d = 1'b0;
    end

    if (xfer) begin
      lock_vld_d = 1'b0;
    end else if (e1_req) begin
      lock_vld_d = 1'b1;
      lock_own_d = win;
    end

    if (!w_req_i || (xfer && win == OWN_W)) begin
      starve_d = 4'd0;
    end else if (xfer && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= OWN_P;
      e2_vld_q   <= 1'b0;
      e2_own_q   <= OWN_P;
      e3_vld_q   <= 1'b0;
      e3_own_q   <= OWN_P;
      starve_q   <= 4'd0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      e2_vld_q   <= e2_vld_d;
      e2_own_q   <= e2_own_d;
      e3_vld_q   <= e3_vld_d;
      e3_own_q   <= e3_own_d;
      starve_q   <= starve_d;
    end
  end

`ifdef MMU_DCACHE_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_hold_q, perf_hold_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_hold_d  = perf_hold_q;
    if (xfer && perf_issue_q != 32'hFFFF_FFFF) perf_issue_d = perf_issue_q + 32'd1;
    if (e1_req && !e1.dcache_e1_grant_i_s && perf_hold_q != 32'hFFFF_FFFF)
      perf_hold_d = perf_hold_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_issue_q <= 32'd0;
      perf_hold_q  <= 32'd0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_hold_q  <= perf_hold_d;
    end
  end

  assign perf_issue_cnt_o = perf_issue_q;
  assign perf_hold_cnt_o  = perf_hold_q;
`endif

endmodule
